// File: rtl/vga_pkg.sv
// Purpose: shared VGA 640x480@60 timing constants and pixel/sync types.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = 800;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = 525;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Bit order matches the delay-line reset value 4'b1100 (syncs idle high).
    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic de;
        logic in_img;
    } sync_bus_t;

    typedef enum logic {
        SW_ARMED,   // a high swap_req at the next frame event swaps banks
        SW_SPENT    // swap done; wait for swap_req to drop before re-arming
    } swap_state_t;

endpackage

// File: rtl/sync_delay_line.sv
// Purpose: fixed-depth shift register carrying sync/flag bits alongside a pipeline.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; advances every clock.
// Ports: clk, reset (async, active-high), din[WIDTH], dout[WIDTH].
module sync_delay_line #(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_fb_reader.sv
// Purpose: maps VGA scan position to double-buffered framebuffer reads with integer upscale.
// Latency: RD_LAT+2 cycles from x/y/sync inputs to aligned sync/DE/rgb outputs.
// Backpressure: none; pixel stream is free-running, bank swap via level req / pulse ack.
// Ports: clk, reset; h_sync_in/v_sync_in/DE_in/x_pixel/y_pixel from the timing generator;
//        swap_req/swap_ack/buf_sel bank handshake; fb_addr/fb_rdata RAM read port;
//        h_sync/v_sync/DE/r_port/g_port/b_port realigned video out.
module vga_fb_reader
    import vga_pkg::*;
#(
    parameter int          IMG_W    = 320,
    parameter int          IMG_H    = 240,
    parameter int          SCALE    = 2,
    parameter int          RD_LAT   = 1,
    parameter logic [23:0] BG_COLOR = 24'h000000,
    localparam int         AW       = $clog2(2*IMG_W*IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          h_sync_in,
    input  logic          v_sync_in,
    input  logic          DE_in,
    input  logic [9:0]    x_pixel,
    input  logic [9:0]    y_pixel,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic          buf_sel,
    output logic [AW-1:0] fb_addr,
    input  logic [23:0]   fb_rdata,
    output logic          h_sync,
    output logic          v_sync,
    output logic          DE,
    output logic [7:0]    r_port,
    output logic [7:0]    g_port,
    output logic [7:0]    b_port
);

    localparam int CW = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [9:0]    X_END      = 10'(IMG_W*SCALE - 1);
    localparam logic [9:0]    Y_END      = 10'(IMG_H*SCALE - 1);
    localparam logic [9:0]    FRAME_Y    = 10'(V_VISIBLE);
    localparam logic [CW-1:0] REP_LAST   = CW'(SCALE - 1);
    localparam logic [AW-2:0] W_STEP     = (AW-1)'(IMG_W);
    localparam logic [AW-1:0] BANK1_BASE = AW'(IMG_W*IMG_H);

    logic [AW-2:0] pix_idx;
    logic [AW-2:0] line_base;
    logic [CW-1:0] col_rep;
    logic [CW-1:0] row_rep;
    logic          synced;
    swap_state_t   swap_state;

    logic frame_evt;
    logic line_last;
    logic in_img;

    assign frame_evt = (y_pixel == FRAME_Y) && (x_pixel == 10'd0);
    assign line_last = (x_pixel == X_END);
    // Counters are only trustworthy after a frame event has cleared them, so
    // image fetches stay suppressed until then (e.g. after a mid-frame reset).
    assign in_img    = synced && DE_in && (x_pixel <= X_END) && (y_pixel <= Y_END);

    // Address generation: replicate each source pixel SCALE times across and
    // each source line SCALE times down, using only adds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_addr   <= '0;
            pix_idx   <= '0;
            line_base <= '0;
            col_rep   <= '0;
            row_rep   <= '0;
            synced    <= 1'b0;
        end else if (frame_evt) begin
            pix_idx   <= '0;
            line_base <= '0;
            col_rep   <= '0;
            row_rep   <= '0;
            synced    <= 1'b1;
        end else if (in_img) begin
            fb_addr <= (buf_sel ? BANK1_BASE : '0) + {1'b0, pix_idx};
            if (line_last) begin
                col_rep <= '0;
                if (row_rep == REP_LAST) begin
                    row_rep   <= '0;
                    line_base <= line_base + W_STEP;
                    pix_idx   <= line_base + W_STEP;
                end else begin
                    row_rep <= row_rep + 1'b1;
                    pix_idx <= line_base;   // repeat the same source line
                end
            end else if (col_rep == REP_LAST) begin
                col_rep <= '0;
                pix_idx <= pix_idx + 1'b1;
            end else begin
                col_rep <= col_rep + 1'b1;
            end
        end
    end

    // Bank swap: one swap per assertion of swap_req, applied only at the
    // frame event so the displayed bank never changes mid-picture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swap_state <= SW_ARMED;
            buf_sel    <= 1'b0;
            swap_ack   <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            case (swap_state)
                SW_ARMED: begin
                    if (frame_evt && swap_req) begin
                        buf_sel    <= ~buf_sel;
                        swap_ack   <= 1'b1;
                        swap_state <= SW_SPENT;
                    end
                end
                SW_SPENT: begin
                    if (!swap_req) begin
                        swap_state <= SW_ARMED;
                    end
                end
                default: swap_state <= SW_ARMED;
            endcase
        end
    end

    // Address register + RD_LAT RAM cycles are covered by RD_LAT+1 delay
    // stages; the output register below supplies the final cycle.
    sync_bus_t dly;

    sync_delay_line #(
        .WIDTH     (4),
        .DEPTH     (RD_LAT + 1),
        .RESET_VAL (4'b1100)
    ) u_sync_dly (
        .clk   (clk),
        .reset (reset),
        .din   ({h_sync_in, v_sync_in, DE_in, in_img}),
        .dout  (dly)
    );

    rgb888_t pix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_sync <= 1'b1;
            v_sync <= 1'b1;
            DE     <= 1'b0;
            pix    <= '0;
        end else begin
            h_sync <= dly.h_sync;
            v_sync <= dly.v_sync;
            DE     <= dly.de;
            if (dly.in_img) begin
                pix <= fb_rdata;
            end else if (dly.de) begin
                pix <= BG_COLOR;
            end else begin
                pix <= '0;
            end
        end
    end

    assign r_port = pix.r;
    assign g_port = pix.g;
    assign b_port = pix.b;

endmodule

// File: tb/tb_vga_fb_reader.sv
module tb_vga_fb_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        h_sync_in = 1'b1;
    logic        v_sync_in = 1'b1;
    logic        DE_in = 1'b0;
    logic [9:0]  x_pixel = '0;
    logic [9:0]  y_pixel = '0;
    logic        swap_req = 1'b0;

    logic        swap_ack, buf_sel, h_sync, v_sync, DE;
    logic [17:0] fb_addr;
    logic [23:0] fb_rdata = '0;
    logic [7:0]  r_port, g_port, b_port;

    logic        swap_ack2, buf_sel2, h_sync2, v_sync2, DE2;
    logic [15:0] fb_addr2;
    logic [23:0] fb_rdata2 = '0;
    logic [7:0]  r_port2, g_port2, b_port2;

    int vec = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Framebuffer contents: an address-dependent pattern, distinct per word.
    function automatic logic [23:0] word(input logic [17:0] a);
        return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C, {6'd0, a[17:16]} ^ 8'h96};
    endfunction

    // RAMs with one cycle read latency.
    always_ff @(posedge clk) begin
        fb_rdata  <= word(fb_addr);
        fb_rdata2 <= word({2'b00, fb_addr2});
    end

    vga_fb_reader dut (
        .clk(clk), .reset(reset),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .DE_in(DE_in),
        .x_pixel(x_pixel), .y_pixel(y_pixel),
        .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel),
        .fb_addr(fb_addr), .fb_rdata(fb_rdata),
        .h_sync(h_sync), .v_sync(v_sync), .DE(DE),
        .r_port(r_port), .g_port(g_port), .b_port(b_port)
    );

    vga_fb_reader #(
        .IMG_W(200), .IMG_H(100), .SCALE(2), .RD_LAT(1), .BG_COLOR(24'h123456)
    ) dut2 (
        .clk(clk), .reset(reset),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .DE_in(DE_in),
        .x_pixel(x_pixel), .y_pixel(y_pixel),
        .swap_req(swap_req), .swap_ack(swap_ack2), .buf_sel(buf_sel2),
        .fb_addr(fb_addr2), .fb_rdata(fb_rdata2),
        .h_sync(h_sync2), .v_sync(v_sync2), .DE(DE2),
        .r_port(r_port2), .g_port(g_port2), .b_port(b_port2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one scan position, then advance to 1 time unit past the edge.
    task automatic step(input int x, input int y, input logic de, input logic hs = 1'b1);
        x_pixel   = x[9:0];
        y_pixel   = y[9:0];
        DE_in     = de;
        h_sync_in = hs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst h_sync", 32'(h_sync), 32'd1);
        chk("rst v_sync", 32'(v_sync), 32'd1);
        chk("rst DE", 32'(DE), 32'd0);
        chk("rst rgb", 32'({r_port, g_port, b_port}), 32'd0);
        chk("rst fb_addr", 32'(fb_addr), 32'd0);
        chk("rst buf_sel", 32'(buf_sel), 32'd0);
        chk("rst swap_ack", 32'(swap_ack), 32'd0);
        reset = 1'b0;
        step(5, 500, 1'b0);

        // Frame event, then 2x upscale addressing on the first three lines
        step(0, 480, 1'b0);
        step(0, 0, 1'b1);   chk("addr y0 x0", 32'(fb_addr), 32'd0);
        step(1, 0, 1'b1);   chk("addr y0 x1", 32'(fb_addr), 32'd0);
        step(2, 0, 1'b1);   chk("addr y0 x2", 32'(fb_addr), 32'd1);
        step(3, 0, 1'b1);   chk("addr y0 x3", 32'(fb_addr), 32'd1);
        step(639, 0, 1'b1);
        step(0, 1, 1'b1);   chk("addr y1 x0", 32'(fb_addr), 32'd0);
        step(1, 1, 1'b1);   chk("addr y1 x1", 32'(fb_addr), 32'd0);
        step(2, 1, 1'b1);   chk("addr y1 x2", 32'(fb_addr), 32'd1);
        step(3, 1, 1'b1);   chk("addr y1 x3", 32'(fb_addr), 32'd1);
        step(639, 1, 1'b1);
        step(0, 2, 1'b1);   chk("addr y2 x0", 32'(fb_addr), 32'd320);
        step(1, 2, 1'b1);   chk("addr y2 x1", 32'(fb_addr), 32'd320);
        step(2, 2, 1'b1);   chk("addr y2 x2", 32'(fb_addr), 32'd321);
        // Outputs trail inputs by three cycles
        chk("rgb y2 x0", 32'({r_port, g_port, b_port}), 32'(word(18'd320)));
        chk("DE y2 x0", 32'(DE), 32'd1);
        step(655, 2, 1'b0, 1'b1);
        chk("rgb y2 x1", 32'({r_port, g_port, b_port}), 32'(word(18'd320)));
        step(656, 2, 1'b0, 1'b0);
        chk("rgb y2 x2", 32'({r_port, g_port, b_port}), 32'(word(18'd321)));
        chk("h_sync +0", 32'(h_sync), 32'd1);
        step(657, 2, 1'b0, 1'b0);
        chk("h_sync +1", 32'(h_sync), 32'd1);
        chk("DE blank", 32'(DE), 32'd0);
        chk("rgb blank", 32'({r_port, g_port, b_port}), 32'd0);
        step(658, 2, 1'b0, 1'b0);
        chk("h_sync +2", 32'(h_sync), 32'd0);
        step(659, 2, 1'b0, 1'b1);
        chk("h_sync +3", 32'(h_sync), 32'd0);

        // Swap requested mid-frame, applied at the frame event
        swap_req = 1'b1;
        step(0, 100, 1'b1);
        step(1, 100, 1'b1);
        chk("no early ack", 32'(swap_ack), 32'd0);
        step(0, 480, 1'b0);
        chk("swap ack", 32'(swap_ack), 32'd1);
        chk("swap buf_sel", 32'(buf_sel), 32'd1);
        step(1, 480, 1'b0);
        chk("ack one cycle", 32'(swap_ack), 32'd0);
        step(0, 0, 1'b1);   chk("bank1 addr x0", 32'(fb_addr), 32'd76800);
        step(1, 0, 1'b1);   chk("bank1 addr x1", 32'(fb_addr), 32'd76800);

        // swap_req still high: no second swap without a fresh assertion
        step(0, 480, 1'b0);
        chk("held req ack", 32'(swap_ack), 32'd0);
        chk("held req buf_sel", 32'(buf_sel), 32'd1);

        // Re-armed request dropped before the frame event
        swap_req = 1'b0;
        step(0, 200, 1'b1);
        swap_req = 1'b1;
        step(1, 200, 1'b1);
        step(0, 470, 1'b1);
        swap_req = 1'b0;
        step(1, 470, 1'b1);
        step(0, 480, 1'b0);
        chk("dropped req ack", 32'(swap_ack), 32'd0);
        chk("dropped req buf_sel", 32'(buf_sel), 32'd1);
        step(1, 480, 1'b0);
        chk("dropped req ack+1", 32'(swap_ack), 32'd0);

        // Small image (400x200 scaled): background outside, black in blanking
        step(0, 0, 1'b1);
        chk("img2 addr", 32'(fb_addr2), 32'd20000);
        step(500, 50, 1'b1);
        chk("img2 addr held", 32'(fb_addr2), 32'd20000);
        step(501, 50, 1'b0);
        chk("img2 rgb in img", 32'({r_port2, g_port2, b_port2}), 32'(word(18'd20000)));
        step(502, 50, 1'b0);
        chk("img2 rgb bg", 32'({r_port2, g_port2, b_port2}), 32'h123456);
        chk("img2 DE bg", 32'(DE2), 32'd1);
        step(503, 50, 1'b0);
        chk("img2 rgb blank", 32'({r_port2, g_port2, b_port2}), 32'd0);
        chk("img2 DE blank", 32'(DE2), 32'd0);

        // Reset asserted mid-line while h_sync output is low and bank 1 shown
        step(10, 5, 1'b1, 1'b0);
        step(11, 5, 1'b1, 1'b0);
        step(12, 5, 1'b1, 1'b0);
        chk("pre-reset h_sync", 32'(h_sync), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid rst h_sync", 32'(h_sync), 32'd1);
        chk("mid rst v_sync", 32'(v_sync), 32'd1);
        chk("mid rst DE", 32'(DE), 32'd0);
        chk("mid rst rgb", 32'({r_port, g_port, b_port}), 32'd0);
        chk("mid rst fb_addr", 32'(fb_addr), 32'd0);
        chk("mid rst buf_sel", 32'(buf_sel), 32'd0);
        chk("mid rst swap_ack", 32'(swap_ack), 32'd0);
        reset = 1'b0;
        step(13, 5, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
